// File: rtl/ks_adder_pipe_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: prefix depth,
// pipeline stage count and the side-band fields carried with each operand.
package ks_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Number of Kogge-Stone prefix levels for a given width.
    function automatic int ks_levels(input int w);
        return clog2(w);
    endfunction

    // Registers after S0: one per REG_EVERY levels, the last also holds the result.
    function automatic int ks_stages(input int w, input int reg_every);
        return (clog2(w) + reg_every - 1) / reg_every;
    endfunction

    // Scalar side-band that travels alongside the prefix vectors.
    typedef struct packed {
        logic c0;       // effective carry-in
        logic a_msb;    // sign of a
        logic b_msb;    // sign of b after optional inversion
    } ks_side_t;

endpackage

// File: rtl/ks_adder_pipe_if.sv
// Operand/result handshake bundle for ks_adder_pipe.
interface ks_adder_pipe_if #(parameter int WIDTH = 12);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/ks_adder_pipe_prefix_level.sv
// One combinational Kogge-Stone row: black cells at distance DIST,
// positions below DIST pass straight through.
module ks_prefix_level #(
    parameter int WIDTH = 12,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i < DIST) begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end else begin : g_black
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
            assign p_o[i] = p_i[i] & p_i[i-DIST];
        end
    end
endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// S0 holds the pre-processed operands, S1..SN follow every REG_EVERY prefix
// levels, and SN holds the post-processed sum/cout/ovf.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int REG_EVERY = 2
) (
    input logic            clk,
    input logic            rst_n,
    ks_adder_pipe_if.slave bus
);
    localparam int LOG2W = ks_levels(WIDTH);
    localparam int N     = ks_stages(WIDTH, REG_EVERY);

    // gg/pp are the running group generate/propagate; p is the raw bitwise
    // propagate needed again for the final XOR.
    typedef struct packed {
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;
        logic [WIDTH-1:0] p;
        ks_side_t         side;
    } stage_t;

    stage_t           st_q [0:N-1];
    stage_t           st_d [0:N-1];
    logic [N:0]       vld_q;
    logic [N:0]       vld_in;
    logic [N:0]       ld;
    logic [WIDTH-1:0] lout_g [0:LOG2W-1];
    logic [WIDTH-1:0] lout_p [0:LOG2W-1];

    logic [WIDTH-1:0] b_eff, p_in, g_in;
    logic             c0;
    logic [WIDTH-1:0] carry, sum_d, sum_q;
    logic             cout_d, ovf_d, cout_q, ovf_q;

    // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub | bus.cin;
    assign p_in  = bus.a ^ b_eff;
    assign g_in  = bus.a & b_eff;

    // Stage inputs. Carry-in is folded into bit 0 as a generate at position -1,
    // whose propagate is 0, so every prefix G[i] is directly carry into i+1.
    for (genvar j = 0; j < N; j++) begin : g_stage
        if (j == 0) begin : g_s0
            assign st_d[0] = '{gg:   {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & c0)},
                               pp:   {p_in[WIDTH-1:1], 1'b0},
                               p:    p_in,
                               side: '{c0: c0, a_msb: bus.a[WIDTH-1], b_msb: b_eff[WIDTH-1]}};
        end else begin : g_sj
            assign st_d[j] = '{gg:   lout_g[j*REG_EVERY-1],
                               pp:   lout_p[j*REG_EVERY-1],
                               p:    st_q[j-1].p,
                               side: st_q[j-1].side};
        end
    end

    // Prefix rows; a row starting a register group reads that stage register.
    for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
        logic [WIDTH-1:0] gi, pi;
        if (k % REG_EVERY == 0) begin : g_from_reg
            assign gi = st_q[k/REG_EVERY].gg;
            assign pi = st_q[k/REG_EVERY].pp;
        end else begin : g_from_row
            assign gi = lout_g[k-1];
            assign pi = lout_p[k-1];
        end
        ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
            .g_i(gi),
            .p_i(pi),
            .g_o(lout_g[k]),
            .p_o(lout_p[k])
        );
    end

    assign carry  = {lout_g[LOG2W-1][WIDTH-2:0], st_q[N-1].side.c0};
    assign sum_d  = st_q[N-1].p ^ carry;
    assign cout_d = lout_g[LOG2W-1][WIDTH-1];
    assign ovf_d  = (st_q[N-1].side.a_msb == st_q[N-1].side.b_msb) &
                    (sum_d[WIDTH-1] != st_q[N-1].side.a_msb);

    assign vld_in = {vld_q[N-1:0], bus.in_valid};

    // Ready chain: a stage loads when empty or when the stage after it loads.
    always_comb begin
        ld    = '0;
        ld[N] = bus.out_ready | ~vld_q[N];
        for (int j = N - 1; j >= 0; j--)
            ld[j] = ~vld_q[j] | ld[j+1];
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_q[N];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Valid shift register with bubble collapsing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int j = 0; j <= N; j++)
                if (ld[j]) vld_q[j] <= vld_in[j];
        end
    end

    // Payload stages move only when a valid item is behind them.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++)
            if (ld[j] && vld_in[j]) st_q[j] <= st_d[j];
    end

    // Result register; held while stalled, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ld[N] && vld_in[N]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule
